// File: rtl/kbd_event_ctrl_if.sv
// Signal bundle between kbd_event_ctrl, the PS/2 receiver and the event consumer.
// The controller uses the master modport; the environment uses slave.
interface kbd_event_ctrl_if;
    logic       en;
    logic       ps2_ready;
    logic [7:0] ps2_keydata;
    logic       ps2_overflow;
    logic       ps2_nextdata_n;
    logic       ps2_clrn;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_release;
    logic [7:0] err_cnt;

    modport master (
        input  en, ps2_ready, ps2_keydata, ps2_overflow, ev_ready,
        output ps2_nextdata_n, ps2_clrn, ev_valid, ev_code, ev_ext, ev_release, err_cnt
    );

    modport slave (
        output en, ps2_ready, ps2_keydata, ps2_overflow, ev_ready,
        input  ps2_nextdata_n, ps2_clrn, ev_valid, ev_code, ev_ext, ev_release, err_cnt
    );
endinterface

// File: rtl/kbd_event_ctrl.sv
// PS/2 scan-code byte consumer: folds E0/F0 prefixes into events held in a FWFT queue.
// Optional macro KBD_TYPEMATIC_FILTER_EN suppresses repeated makes of the held key.
module kbd_event_ctrl #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned RECOVER_CYC = 4
) (
    input  logic             clk,
    input  logic             reset,
    kbd_event_ctrl_if.master bus
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned RcW  = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC + 1) : 1;

    typedef enum logic [1:0] {StIdle, StAck, StRecover} state_e;

    state_e          state_q;
    logic [7:0]      byte_q;
    logic            ext_q;
    logic            rel_q;
    logic            nextdata_n_q;
    logic            clrn_q;
    logic [RcW-1:0]  rc_cnt_q;
    logic [7:0]      err_cnt_q;
    logic            push_valid_q;
    logic [9:0]      push_entry_q;

    logic [CntW-1:0] count_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [9:0]      mem [FIFO_DEPTH];

    logic is_ext_pfx;
    logic is_rel_pfx;
    logic has_room;
    logic pop;
    logic drop;

    assign is_ext_pfx = (byte_q == 8'hE0);
    assign is_rel_pfx = (byte_q == 8'hF0);
    assign pop        = (count_q != '0) && bus.ev_ready;
    // An entry decoded but not yet written still owns a slot.
    assign has_room   = ({1'b0, count_q} + {{CntW{1'b0}}, push_valid_q})
                        < (CntW + 1)'(FIFO_DEPTH);

`ifdef KBD_TYPEMATIC_FILTER_EN
    logic       held_valid_q;
    logic [8:0] held_q;

    assign drop = !rel_q && held_valid_q && (held_q == {ext_q, byte_q});
`else
    assign drop = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            byte_q       <= 8'h00;
            ext_q        <= 1'b0;
            rel_q        <= 1'b0;
            nextdata_n_q <= 1'b1;
            clrn_q       <= 1'b0;
            rc_cnt_q     <= '0;
            err_cnt_q    <= 8'h00;
            push_valid_q <= 1'b0;
            push_entry_q <= 10'h000;
`ifdef KBD_TYPEMATIC_FILTER_EN
            held_valid_q <= 1'b0;
            held_q       <= 9'h000;
`endif
        end else begin
            nextdata_n_q <= 1'b1;
            clrn_q       <= 1'b1;
            push_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.ps2_overflow) begin
                        state_q  <= StRecover;
                        clrn_q   <= 1'b0;
                        rc_cnt_q <= RcW'(RECOVER_CYC - 1);
                        ext_q    <= 1'b0;
                        rel_q    <= 1'b0;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
`ifdef KBD_TYPEMATIC_FILTER_EN
                        held_valid_q <= 1'b0;
`endif
                    end else if (bus.en && bus.ps2_ready && has_room) begin
                        byte_q       <= bus.ps2_keydata;
                        nextdata_n_q <= 1'b0;
                        state_q      <= StAck;
                    end
                end
                StAck: begin
                    state_q <= StIdle;
                    if (is_ext_pfx) begin
                        ext_q <= 1'b1;
                    end else if (is_rel_pfx) begin
                        rel_q <= 1'b1;
                    end else begin
                        ext_q        <= 1'b0;
                        rel_q        <= 1'b0;
                        push_valid_q <= !drop;
                        push_entry_q <= {ext_q, rel_q, byte_q};
`ifdef KBD_TYPEMATIC_FILTER_EN
                        if (!rel_q) begin
                            held_valid_q <= 1'b1;
                            held_q       <= {ext_q, byte_q};
                        end else if (held_q == {ext_q, byte_q}) begin
                            held_valid_q <= 1'b0;
                        end
`endif
                    end
                end
                StRecover: begin
                    if (rc_cnt_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        rc_cnt_q <= rc_cnt_q - RcW'(1);
                        clrn_q   <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_valid_q) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push_valid_q && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!push_valid_q && pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Storage needs no reset; ev_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (push_valid_q) begin
            mem[wr_ptr_q] <= push_entry_q;
        end
    end

    assign bus.ev_valid                             = (count_q != '0);
    assign {bus.ev_ext, bus.ev_release, bus.ev_code} = mem[rd_ptr_q];
    assign bus.ps2_nextdata_n                       = nextdata_n_q;
    assign bus.ps2_clrn                             = clrn_q;
    assign bus.err_cnt                              = err_cnt_q;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Directed bench for kbd_event_ctrl: a byte-feeding PS/2 receiver model plus an event monitor.
// Expected event count of the typematic scenario follows KBD_TYPEMATIC_FILTER_EN.
module tb_kbd_event_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;

    kbd_event_ctrl_if bus ();

    kbd_event_ctrl #(
        .FIFO_DEPTH (4),
        .RECOVER_CYC(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Receiver model: bytes in feed_mem[feed_rd..feed_wr); popped on the strobe, flushed on clear.
    logic [7:0] feed_mem [256];
    logic [7:0] feed_wr = 8'd0;
    logic [7:0] feed_rd = 8'd0;
    int         ovf_req = 0;
    int         ovf_ack = 0;

    always @(negedge clk) begin
        if (bus.ps2_clrn === 1'b0) begin
            feed_rd          = feed_wr;
            bus.ps2_overflow = 1'b0;
            ovf_ack          = ovf_req;
        end else begin
            if (bus.ps2_nextdata_n === 1'b0 && feed_rd != feed_wr) begin
                feed_rd = feed_rd + 8'd1;
            end
            if (ovf_req != ovf_ack) begin
                bus.ps2_overflow = 1'b1;
                ovf_ack          = ovf_req;
            end
        end
        bus.ps2_ready   = (feed_rd != feed_wr);
        bus.ps2_keydata = feed_mem[feed_rd];
    end

    // Event monitor: packed {ext, rel, code}; handshake inputs are stable from negedge to posedge.
    logic [9:0] got_mem [256];
    logic [7:0] got_cnt = 8'd0;
    logic [7:0] got_rd  = 8'd0;

    always @(negedge clk) begin
        if (!reset && bus.ev_valid === 1'b1 && bus.ev_ready === 1'b1) begin
            got_mem[got_cnt] = {bus.ev_ext, bus.ev_release, bus.ev_code};
            got_cnt          = got_cnt + 8'd1;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] b);
        feed_mem[feed_wr] = b;
        feed_wr           = feed_wr + 8'd1;
    endtask

    task automatic wait_events(input int n, input int budget);
        for (int i = 0; i < budget && int'(got_cnt - got_rd) < n; i++) begin
            cycles(1);
        end
    endtask

    // Leaves the caller on the negedge inside the pop-strobe cycle.
    task automatic wait_pop(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ps2_nextdata_n === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        cycles(3);
        checks++;
        if (bus.ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ev_valid: got %b want 0", bus.ev_valid);
        end
        checks++;
        if (bus.ps2_nextdata_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_nextdata_n: got %b want 1", bus.ps2_nextdata_n);
        end
        checks++;
        if (bus.ps2_clrn !== 1'b0) begin
            errors++;
            $display("FAIL reset_clrn: got %b want 0", bus.ps2_clrn);
        end
        checks++;
        if (bus.err_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_err_cnt: got %h want 00", bus.err_cnt);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.ps2_clrn !== 1'b0) begin
            errors++;
            $display("FAIL release_clrn_before_edge: got %b want 0", bus.ps2_clrn);
        end
        cycles(1);
        checks++;
        if (bus.ps2_clrn !== 1'b1) begin
            errors++;
            $display("FAIL release_clrn_after_edge: got %b want 1", bus.ps2_clrn);
        end
    endtask

    task automatic test_make_break;
        bus.ev_ready = 1'b1;
        feed(8'h1C); feed(8'hF0); feed(8'h1C);
        wait_events(2, 100);
        cycles(10);
        checks++;
        if (got_cnt - got_rd !== 8'd2) begin
            errors++;
            $display("FAIL make_break_count: got %0d want 2", got_cnt - got_rd);
        end
        checks++;
        if (got_mem[got_rd] !== 10'h01C) begin
            errors++;
            $display("FAIL make_break_ev0: got %h want 01c", got_mem[got_rd]);
        end
        checks++;
        if (got_mem[got_rd + 8'd1] !== 10'h11C) begin
            errors++;
            $display("FAIL make_break_ev1: got %h want 11c", got_mem[got_rd + 8'd1]);
        end
        got_rd = got_cnt;
    endtask

    task automatic test_extended;
        bus.ev_ready = 1'b1;
        feed(8'hE0); feed(8'h75); feed(8'hE0); feed(8'hF0); feed(8'h75);
        wait_events(2, 150);
        cycles(10);
        checks++;
        if (got_cnt - got_rd !== 8'd2) begin
            errors++;
            $display("FAIL extended_count: got %0d want 2", got_cnt - got_rd);
        end
        checks++;
        if (got_mem[got_rd] !== 10'h275) begin
            errors++;
            $display("FAIL extended_ev0: got %h want 275", got_mem[got_rd]);
        end
        checks++;
        if (got_mem[got_rd + 8'd1] !== 10'h375) begin
            errors++;
            $display("FAIL extended_ev1: got %h want 375", got_mem[got_rd + 8'd1]);
        end
        got_rd = got_cnt;
    endtask

    task automatic test_enable;
        bit ok;
        bus.ev_ready = 1'b1;
        bus.en       = 1'b0;
        feed(8'h2A);
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.ps2_nextdata_n !== 1'b1) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL enable_low_no_pop: got strobe want none");
        end
        checks++;
        if (feed_wr - feed_rd !== 8'd1) begin
            errors++;
            $display("FAIL enable_low_pending: got %0d want 1", feed_wr - feed_rd);
        end
        @(posedge clk);
        #1;
        bus.en = 1'b1;
        wait_events(1, 40);
        checks++;
        if (got_cnt == got_rd || got_mem[got_rd] !== 10'h02A) begin
            errors++;
            $display("FAIL enable_high_event: got %h (n=%0d) want 02a", got_mem[got_rd],
                     got_cnt - got_rd);
        end
        got_rd = got_cnt;
    endtask

    task automatic test_latency;
        bit found;
        bus.ev_ready = 1'b0;
        feed(8'h1C);
        wait_pop(found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL latency_pop_seen: got none want strobe");
        end
        @(negedge clk);
        checks++;
        if (bus.ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_plus1: got ev_valid %b want 0", bus.ev_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.ev_valid !== 1'b1 || bus.ev_code !== 8'h1C) begin
            errors++;
            $display("FAIL latency_plus2: got valid %b code %h want 1 1c", bus.ev_valid,
                     bus.ev_code);
        end
        @(posedge clk);
        #1;
        bus.ev_ready = 1'b1;
        wait_events(1, 20);
        cycles(2);
        got_rd = got_cnt;
    endtask

    task automatic test_backpressure;
        bit ok;
        logic [9:0] exp [5];
        exp[0] = 10'h015; exp[1] = 10'h01D; exp[2] = 10'h024; exp[3] = 10'h02D; exp[4] = 10'h02C;
        bus.ev_ready = 1'b0;
        for (int i = 0; i < 5; i++) feed(exp[i][7:0]);
        cycles(40);
        checks++;
        if (bus.ev_valid !== 1'b1 || bus.ev_code !== 8'h15) begin
            errors++;
            $display("FAIL full_head: got valid %b code %h want 1 15", bus.ev_valid, bus.ev_code);
        end
        ok = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus.ps2_nextdata_n !== 1'b1 || bus.ps2_ready !== 1'b1) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL full_stall: got strobe or no ready want stalled with ready");
        end
        checks++;
        if (feed_wr - feed_rd !== 8'd1) begin
            errors++;
            $display("FAIL full_pending: got %0d want 1", feed_wr - feed_rd);
        end
        @(posedge clk);
        #1;
        bus.ev_ready = 1'b1;
        wait_events(5, 100);
        cycles(5);
        checks++;
        if (got_cnt - got_rd !== 8'd5) begin
            errors++;
            $display("FAIL full_drain_count: got %0d want 5", got_cnt - got_rd);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_mem[got_rd + 8'(i)] !== exp[i]) begin
                errors++;
                $display("FAIL full_order[%0d]: got %h want %h", i, got_mem[got_rd + 8'(i)],
                         exp[i]);
            end
        end
        got_rd = got_cnt;
    endtask

    task automatic test_overflow;
        bit found;
        int low;
        bus.ev_ready = 1'b1;
        feed(8'hE0);
        cycles(10);
        ovf_req++;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ps2_clrn === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        low = 0;
        while (found && bus.ps2_clrn === 1'b0 && low < 20) begin
            low++;
            @(negedge clk);
        end
        checks++;
        if (low != 4) begin
            errors++;
            $display("FAIL recover_clrn_cycles: got %0d want 4", low);
        end
        checks++;
        if (bus.err_cnt !== 8'h01) begin
            errors++;
            $display("FAIL recover_err_cnt: got %h want 01", bus.err_cnt);
        end
        @(posedge clk);
        #1;
        feed(8'h1C);
        wait_events(1, 50);
        cycles(5);
        checks++;
        if (got_cnt - got_rd !== 8'd1 || got_mem[got_rd] !== 10'h01C) begin
            errors++;
            $display("FAIL recover_ext_dropped: got %h (n=%0d) want 01c", got_mem[got_rd],
                     got_cnt - got_rd);
        end
        got_rd = got_cnt;
    endtask

    task automatic test_reset_mid_ack;
        bit found;
        bus.ev_ready = 1'b0;
        feed(8'h15); feed(8'h1D);
        cycles(20);
        checks++;
        if (bus.ev_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_ack_pre_valid: got %b want 1", bus.ev_valid);
        end
        feed(8'h24);
        wait_pop(found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_ack_pop_seen: got none want strobe");
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.ev_valid !== 1'b0 || bus.err_cnt !== 8'h00) begin
            errors++;
            $display("FAIL mid_ack_async: got valid %b err %h want 0 00", bus.ev_valid,
                     bus.err_cnt);
        end
        checks++;
        if (bus.ps2_clrn !== 1'b0 || bus.ps2_nextdata_n !== 1'b1) begin
            errors++;
            $display("FAIL mid_ack_async_ps2: got clrn %b nd %b want 0 1", bus.ps2_clrn,
                     bus.ps2_nextdata_n);
        end
        cycles(2);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.ps2_clrn !== 1'b0) begin
            errors++;
            $display("FAIL mid_ack_clrn_held: got %b want 0", bus.ps2_clrn);
        end
        cycles(1);
        checks++;
        if (bus.ps2_clrn !== 1'b1) begin
            errors++;
            $display("FAIL mid_ack_clrn_release: got %b want 1", bus.ps2_clrn);
        end
        cycles(8);
        checks++;
        if (bus.ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_ack_discard: got ev_valid %b want 0", bus.ev_valid);
        end
        got_rd = got_cnt;
    endtask

    task automatic test_typematic;
`ifdef KBD_TYPEMATIC_FILTER_EN
        int exp_n = 2;
`else
        int exp_n = 4;
`endif
        bus.ev_ready = 1'b1;
        feed(8'h1C); feed(8'h1C); feed(8'h1C); feed(8'hF0); feed(8'h1C);
        wait_events(exp_n, 150);
        cycles(20);
        checks++;
        if (int'(got_cnt - got_rd) != exp_n) begin
            errors++;
            $display("FAIL typematic_count: got %0d want %0d", got_cnt - got_rd, exp_n);
        end
        checks++;
        if (got_mem[got_rd] !== 10'h01C) begin
            errors++;
            $display("FAIL typematic_first: got %h want 01c", got_mem[got_rd]);
        end
        checks++;
        if (got_mem[got_cnt - 8'd1] !== 10'h11C) begin
            errors++;
            $display("FAIL typematic_last: got %h want 11c", got_mem[got_cnt - 8'd1]);
        end
        got_rd = got_cnt;
    endtask

    initial begin
        bus.en       = 1'b1;
        bus.ev_ready = 1'b0;
        test_reset();
        test_make_break();
        test_extended();
        test_enable();
        test_latency();
        test_backpressure();
        test_overflow();
        test_reset_mid_ack();
        test_typematic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
